// File: rtl/sa_sequencer.sv
// sa_sequencer: runs one Y = X*W job on an output-stationary systolic array (clear, feed, drain, hand off).
// Optional SA_SEQ_PERF_EN adds perf_cycles/perf_stall counters for the last completed job.
module sa_sequencer #(
    parameter int M          = 5,
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int PIPE_LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       x_rd_en,
    output logic [ADDR_WIDTH-1:0]      x_rd_addr,
    input  logic [DATA_WIDTH*M-1:0]    x_rd_data,
    output logic                       w_rd_en,
    output logic [ADDR_WIDTH-1:0]      w_rd_addr,
    input  logic [DATA_WIDTH*K-1:0]    w_rd_data,
    output logic                       sa_rst_n,
    output logic [DATA_WIDTH*M-1:0]    sa_x,
    output logic [DATA_WIDTH*K-1:0]    sa_w,
    input  logic [DATA_WIDTH*M*K-1:0]  sa_y,
    output logic [DATA_WIDTH*M*K-1:0]  y_data,
    output logic                       y_valid,
`ifdef SA_SEQ_PERF_EN
    input  logic                       y_ready,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_stall
`else
    input  logic                       y_ready
`endif
);
    localparam int D  = M + K - 2 + PIPE_LAT;
    localparam int BW = $clog2(N + 1);
    localparam int CW = $clog2(D + 1);
    localparam logic [ADDR_WIDTH-1:0] AMAX = ADDR_WIDTH'(N - 1);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, FEED = 3'd2, DRAIN = 3'd3, OUTPUT = 3'd4;

    logic [2:0]            state;
    logic [BW-1:0]         beat;
    logic [CW-1:0]         cnt;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  more;

    // another read is due while the last issued address is below N-1
    assign more      = addr < AMAX;
    assign busy      = state != IDLE;
    assign sa_rst_n  = rst_n && state != CLEAR;
    assign sa_x      = state == FEED ? x_rd_data : '0;
    assign sa_w      = state == FEED ? w_rd_data : '0;
    assign x_rd_en   = rd_en;
    assign w_rd_en   = rd_en;
    assign x_rd_addr = addr;
    assign w_rd_addr = addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            cnt     <= '0;
            rd_en   <= 1'b0;
            addr    <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CLEAR;
                    rd_en <= 1'b1;
                    addr  <= '0;
                end
                CLEAR: begin
                    state <= FEED;
                    beat  <= '0;
                    rd_en <= more;
                    addr  <= addr + ADDR_WIDTH'(more);
                end
                FEED: begin
                    beat  <= beat + BW'(1);
                    rd_en <= more;
                    addr  <= addr + ADDR_WIDTH'(more);
                    if (beat == BW'(N - 1)) begin
                        state <= DRAIN;
                        cnt   <= CW'(D - 1);
                    end
                end
                DRAIN: if (cnt == '0) begin
                    y_data  <= sa_y;
                    y_valid <= 1'b1;
                    state   <= OUTPUT;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                OUTPUT: if (y_ready) begin
                    y_valid <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SA_SEQ_PERF_EN
    logic [31:0] pc, ps;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            ps          <= '0;
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            pc <= busy ? pc + 32'd1 : '0;
            ps <= state == OUTPUT && !y_ready ? ps + 32'd1 : busy ? ps : '0;
            if (state == OUTPUT && y_ready) begin
                perf_cycles <= pc + 32'd1;
                perf_stall  <= ps;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: two sequencer instances (N=2 and N=1) driving a behavioural systolic array,
// scoreboarded against the plain matrix product.
module tb_sa_sequencer;
    localparam int M  = 2;
    localparam int K  = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PL = 2;
    localparam int D  = M + K - 2 + PL;
    localparam int YW = DW * M * K;
    localparam int L  = M + K - 1;

    logic clk = 1'b0;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (inst %0d, cycle %0d): got %0h, expected %0h", nm, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int N = (g == 0) ? 2 : 1;

        logic rst_n = 1'b0, start = 1'b0, y_ready = 1'b0, rq = 1'b0, fin = 1'b0;
        logic busy, done, x_rd_en, w_rd_en, sa_rst_n, y_valid;
        logic [AW-1:0] x_rd_addr, w_rd_addr;
        logic [DW*M-1:0] x_rd_data = '0;
        logic [DW*K-1:0] w_rd_data = '0;
        logic [DW*M-1:0] sa_x;
        logic [DW*K-1:0] sa_w;
        logic [YW-1:0] sa_y, y_data;
`ifdef SA_SEQ_PERF_EN
        logic [31:0] perf_cycles, perf_stall;
`endif
        logic [DW-1:0] xm [256][M];
        logic [DW-1:0] wm [256][K];
        logic [YW-1:0] qy [$];
        int qt [$];
        int qs [$];

        sa_sequencer #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
            .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
            .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
            .sa_rst_n(sa_rst_n), .sa_x(sa_x), .sa_w(sa_w), .sa_y(sa_y),
            .y_data(y_data), .y_valid(y_valid),
`ifdef SA_SEQ_PERF_EN
            .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
            .y_ready(y_ready)
        );

        // operand buffers with one cycle read latency
        always @(posedge clk) begin
            rq <= rst_n;
            for (int i = 0; i < M; i++) if (x_rd_en) x_rd_data[i*DW +: DW] <= xm[x_rd_addr][i];
            for (int j = 0; j < K; j++) if (w_rd_en) w_rd_data[j*DW +: DW] <= wm[w_rd_addr][j];
        end

        // array: operands reach PE(i,j) i+j cycles late, then accumulate and output registers
        logic [DW-1:0] xd [L][M], wd [L][K], hx [L-1][M], hw [L-1][K], acc [M][K], yr [M][K];

        always_comb begin
            for (int i = 0; i < M; i++) xd[0][i] = sa_x[i*DW +: DW];
            for (int j = 0; j < K; j++) wd[0][j] = sa_w[j*DW +: DW];
            for (int d = 1; d < L; d++) begin
                for (int i = 0; i < M; i++) xd[d][i] = hx[d-1][i];
                for (int j = 0; j < K; j++) wd[d][j] = hw[d-1][j];
            end
            sa_y = '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++) sa_y[(i*K+j)*DW +: DW] = yr[i][j];
        end

        always @(posedge clk) begin
            for (int d = 0; d < L - 1; d++) begin
                for (int i = 0; i < M; i++) hx[d][i] <= sa_rst_n ? xd[d][i] : '0;
                for (int j = 0; j < K; j++) hw[d][j] <= sa_rst_n ? wd[d][j] : '0;
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++) begin
                    acc[i][j] <= sa_rst_n ? acc[i][j] + xd[i+j][i] * wd[i+j][j] : '0;
                    yr[i][j]  <= sa_rst_n ? acc[i][j] : '0;
                end
        end

        // monitor: compares every presented result against the scoreboard head
        initial begin
            logic pv, pd;
            logic [YW-1:0] held;
            int xs, ws, stalls, cs;
            pv = 1'b0; pd = 1'b0; held = '0; xs = 0; ws = 0; stalls = 0; cs = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) chk("sa_rst_n_in_reset", g, sa_rst_n, 0);
                if (!rq) begin
                    chk("reset_outputs", g, {busy, done, y_valid, x_rd_en, w_rd_en}, 0);
                    pv = 1'b0; pd = 1'b0; xs = 0; ws = 0; stalls = 0;
                end else begin
                    if (x_rd_en) begin chk("x_addr_range", g, x_rd_addr < N, 1); xs++; end
                    if (w_rd_en) begin chk("w_addr_range", g, w_rd_addr < N, 1); ws++; end
                    chk("done_pulse", g, done, pd);
                    if (pd) begin
                        chk("idle_after_done", g, {busy, y_valid}, 0);
`ifdef SA_SEQ_PERF_EN
                        chk("perf_cycles", g, perf_cycles, cyc - cs - 1);
                        chk("perf_stall", g, perf_stall, stalls);
`endif
                        stalls = 0;
                    end
                    pd = 1'b0;
                    if (y_valid && !pv) begin
                        if (qy.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_result (inst %0d, cycle %0d): got %0h, expected no result", g, cyc, y_data);
                        end else begin
                            chk("y_data", g, y_data, qy[0]);
                            chk("latency", g, cyc, qt[0]);
                            chk("x_strobes", g, xs, N);
                            chk("w_strobes", g, ws, N);
                            chk("busy_in_output", g, busy, 1);
                        end
                        held = y_data; xs = 0; ws = 0;
                    end else if (y_valid) begin
                        chk("y_hold", g, y_data, held);
                    end
                    if (y_valid && !y_ready) stalls++;
                    if (y_valid && y_ready) begin
                        pd = 1'b1;
                        if (qy.size() != 0) begin
                            cs = qs[0];
                            void'(qy.pop_front()); void'(qt.pop_front()); void'(qs.pop_front());
                        end
                    end
                    pv = y_valid;
                end
            end
        end

        // pat: 0 random, 1 directed example, 2 all ones; mode: 0 ready, 1 random ready, 2 seven-cycle stall
        task automatic run_job(input int pat, input int mode, input bit abort);
            logic [DW-1:0] x [M][N];
            logic [DW-1:0] w [N][K];
            logic [DW-1:0] s;
            logic [YW-1:0] e;
            int c, vc;
            for (int i = 0; i < M; i++)
                for (int k = 0; k < N; k++) x[i][k] = pat == 0 ? $urandom : pat == 2 ? 1 : (N == 2 ? i * 2 + k + 1 : i + 3);
            for (int k = 0; k < N; k++)
                for (int j = 0; j < K; j++) w[k][j] = pat == 0 ? $urandom : pat == 2 ? 1 : (N == 2 ? k * 2 + j + 5 : j + 5);
            e = '0;
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < M; i++) xm[k][i] = x[i][k];
                for (int j = 0; j < K; j++) wm[k][j] = w[k][j];
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++) begin
                    s = '0;
                    for (int k = 0; k < N; k++) s += x[i][k] * w[k][j];
                    e[(i*K+j)*DW +: DW] = s;
                end
            y_ready = mode == 0;
            @(posedge clk); #1;
            start = 1'b1;
            c = cyc;
            if (!abort) begin qy.push_back(e); qt.push_back(c + 2 + N + D); qs.push_back(c); end
            @(posedge clk); #1;
            start = 1'b0;
            vc = 0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                if (abort) begin
                    rst_n = i != 0;
                    if (i == 6) return;
                end else begin
                    if (done) return;
                    if (y_valid) vc++;
                    start = mode == 2 && (i == 3 || vc == 3);
                    y_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : vc > 7;
                end
            end
            checks++; errors++;
            $display("FAIL job_timeout (inst %0d, cycle %0d): got no done, expected done within 200 cycles", g, cyc);
        endtask

        initial begin
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk("idle_quiet", g, {busy, y_valid, x_rd_en, w_rd_en, done, sa_rst_n}, 6'b000001);
            end
            run_job(1, 0, 0);
            run_job(1, 2, 0);
            run_job(2, 0, 0);
            run_job(0, 0, 1);
            run_job(1, 0, 0);
            for (int t = 0; t < 20; t++) run_job(0, t % 3, 0);
            repeat (3) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(h[0].fin && h[1].fin); i++) @(posedge clk);
        if (!(h[0].fin && h[1].fin)) begin
            checks++; errors++;
            $display("FAIL global_timeout: got unfinished stimulus, expected completion within 20000 cycles");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
